// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC storage, interrupt/exception arbitration and mfc0/mtc0 access.
// Sits at the macro-PC point; Req and DOut are combinational, all state updates on clk.
module cp0_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter bit          ALIGN_EPC    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        WE,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPCout,
    output logic [31:0] DOut
);

    localparam logic [4:0] RegSr    = 5'd12;
    localparam logic [4:0] RegCause = 5'd13;
    localparam logic [4:0] RegEpc   = 5'd14;

    // Only the architected fields are stored; everything else reads as zero.
    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;

    logic [5:0]  w_sr_im_d;
    logic        w_sr_exl_d;
    logic        w_sr_ie_d;
    logic        w_cause_bd_d;
    logic [4:0]  w_cause_exc_d;
    logic [31:0] w_epc_d;

    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_epc_fault;
    logic [31:0] w_sr_word;
    logic [31:0] w_cause_word;

    function automatic logic [31:0] f_align(input logic [31:0] v);
        f_align = ALIGN_EPC ? {v[31:2], 2'b00} : v;
    endfunction

    assign w_int_req   = (|(HWInt & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    assign w_exc_req   = (ExcCodeIn != 5'd0) & ~r_sr_exl;
    assign Req         = w_int_req | w_exc_req;
    // Delay-slot faults restart at the branch so the branch is re-executed.
    assign w_epc_fault = BDIn ? (VPC - 32'd4) : VPC;

    assign w_sr_word    = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
    assign w_cause_word = {r_cause_bd, 15'd0, r_cause_ip, 3'd0, r_cause_exc, 2'd0};

    always_comb begin
        w_sr_im_d     = r_sr_im;
        w_sr_exl_d    = r_sr_exl;
        w_sr_ie_d     = r_sr_ie;
        w_cause_bd_d  = r_cause_bd;
        w_cause_exc_d = r_cause_exc;
        w_epc_d       = r_epc;
        if (Req) begin
            // The faulting instruction does not commit, so its mtc0/eret are dropped.
            w_sr_exl_d    = 1'b1;
            w_cause_exc_d = w_int_req ? 5'd0 : ExcCodeIn;
            w_cause_bd_d  = BDIn;
            w_epc_d       = f_align(w_epc_fault);
        end else begin
            if (WE && (A2 == RegSr)) begin
                w_sr_im_d  = DIn[15:10];
                w_sr_exl_d = DIn[1];
                w_sr_ie_d  = DIn[0];
            end
            if (WE && (A2 == RegEpc)) begin
                w_epc_d = f_align(DIn);
            end
            if (EXLClr) begin
                w_sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= 6'd0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= 6'd0;
            r_cause_exc <= 5'd0;
            r_epc       <= 32'd0;
        end else begin
            r_sr_im     <= w_sr_im_d;
            r_sr_exl    <= w_sr_exl_d;
            r_sr_ie     <= w_sr_ie_d;
            r_cause_bd  <= w_cause_bd_d;
            r_cause_ip  <= HWInt;
            r_cause_exc <= w_cause_exc_d;
            r_epc       <= w_epc_d;
        end
    end

    always_comb begin
        DOut = 32'd0;
        case (A1)
            RegSr:    DOut = w_sr_word;
            RegCause: DOut = w_cause_word;
            RegEpc:   DOut = r_epc;
            default:  DOut = 32'd0;
        endcase
    end

    assign EPCout = r_epc;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios followed by randomized cycles, all checked
// against a word-level model of the SR/Cause/EPC registers.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, ExcCodeIn;
    logic [31:0] DIn, VPC;
    logic        BDIn, WE, EXLClr;
    logic [5:0]  HWInt;
    logic        Req;
    logic [31:0] EPCout, DOut;

    int n_checks = 0;
    int n_errors = 0;

    // Model state kept as whole architectural words.
    logic [31:0] m_sr, m_cause, m_epc;

    cp0_unit #(.HANDLER_ADDR(32'h0000_4180), .ALIGN_EPC(1'b1)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .VPC(VPC),
        .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .WE(WE),
        .EXLClr(EXLClr), .Req(Req), .EPCout(EPCout), .DOut(DOut)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] SrMask    = 32'h0000_FC03;
    localparam logic [31:0] CauseMask = 32'h8000_FC7C;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic m_req();
        logic exl, ie;
        logic [5:0] im;
        exl = m_sr[1];
        ie  = m_sr[0];
        im  = m_sr[15:10];
        return (((HWInt & im) != 0) && ie && !exl) || ((ExcCodeIn != 0) && !exl);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 12) return m_sr;
        if (a == 13) return m_cause;
        if (a == 14) return m_epc;
        return 32'd0;
    endfunction

    task automatic model_edge();
        logic ireq, req;
        logic [31:0] target;
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
            return;
        end
        ireq = ((HWInt & m_sr[15:10]) != 0) && m_sr[0] && !m_sr[1];
        req  = m_req();
        m_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
        if (req) begin
            m_sr    = m_sr | 32'h2;
            m_cause = (m_cause & ~32'h8000_007C) | (32'(BDIn) << 31)
                      | (ireq ? 32'd0 : (32'(ExcCodeIn) << 2));
            target  = BDIn ? VPC - 4 : VPC;
            m_epc   = target & ~32'd3;
        end else begin
            if (WE && A2 == 12) m_sr = DIn & SrMask;
            if (WE && A2 == 14) m_epc = DIn & ~32'd3;
            if (EXLClr) m_sr = m_sr & ~32'h2;
        end
    endtask

    task automatic cycle();
        #1;
        chk("req", 32'(Req), 32'(m_req()));
        chk("epcout", EPCout, m_epc);
        chk("dout", DOut, m_read(A1));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset = 0; WE = 0; A2 = 0; DIn = 0; EXLClr = 0;
        ExcCodeIn = 0; HWInt = 0; BDIn = 0; VPC = 32'h0000_2000;
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        A1 = a;
        #1;
        chk(tag, DOut, exp);
    endtask

    initial begin
        m_sr = 'x; m_cause = 'x; m_epc = 'x;
        idle();
        A1 = 12;
        reset = 1;
        @(posedge clk);
        model_edge();
        #1;
        idle();
        peek("rst_sr", 12, 32'd0);
        peek("rst_cause", 13, 32'd0);
        peek("rst_epc", 14, 32'd0);
        chk("rst_req", 32'(Req), 32'd0);

        // Enable IM[0] + IE, then raise HWInt[0].
        WE = 1; A2 = 12; DIn = 32'h0000_0401;
        cycle();
        idle();
        HWInt = 6'b000001; VPC = 32'h0000_2000;
        #1 chk("int_req_now", 32'(Req), 32'd1);
        cycle();
        idle();
        HWInt = 6'b000001;
        peek("int_sr", 12, 32'h0000_0403);
        peek("int_cause", 13, 32'h0000_0400);
        chk("int_epc", EPCout, 32'h0000_2000);
        chk("int_req_masked", 32'(Req), 32'd0);

        // eret, then an overflow in a delay slot.
        idle(); EXLClr = 1;
        cycle();
        idle();
        ExcCodeIn = 5'd12; VPC = 32'h0000_3010; BDIn = 1;
        #1 chk("ov_req", 32'(Req), 32'd1);
        cycle();
        idle();
        chk("ov_epc", EPCout, 32'h0000_300C);
        peek("ov_cause", 13, 32'h8000_0030);

        // Interrupt vs exception in the same cycle; concurrent mtc0 EPC is dropped.
        EXLClr = 1;
        cycle();
        idle();
        HWInt = 6'b000001; ExcCodeIn = 5'd10; VPC = 32'h0000_3100;
        WE = 1; A2 = 14; DIn = 32'hDEAD_0000;
        cycle();
        idle();
        HWInt = 6'b000001;
        peek("prio_cause", 13, 32'h0000_0400);
        chk("prio_epc", EPCout, 32'h0000_3100);

        // EXL masks everything; eret re-opens the interrupt window.
        ExcCodeIn = 5'd4;
        #1 chk("exl_mask", 32'(Req), 32'd0);
        cycle();
        peek("exl_cause_kept", 13, 32'h0000_0400);
        ExcCodeIn = 0; EXLClr = 1;
        cycle();
        EXLClr = 0;
        peek("eret_sr", 12, 32'h0000_0401);
        chk("eret_int_taken", 32'(Req), 32'd1);
        cycle();

        // Cause is read-only; EPC write is word aligned.
        idle();
        WE = 1; A2 = 13; DIn = 32'hFFFF_FFFF;
        cycle();
        idle();
        peek("cause_ro", 13, 32'h0000_0000);
        WE = 1; A2 = 14; DIn = 32'h0000_3007;
        cycle();
        idle();
        peek("epc_wr", 14, 32'h0000_3004);
        chk("epc_out_wr", EPCout, 32'h0000_3004);

        // Reset with EXL set and a pending exception.
        reset = 1; ExcCodeIn = 5'd8;
        cycle();
        idle();
        peek("rst2_sr", 12, 32'd0);
        peek("rst2_epc", 14, 32'd0);
        chk("rst2_req", 32'(Req), 32'd0);

        // Delay-slot fault at PC 0 wraps.
        ExcCodeIn = 5'd5; VPC = 32'd0; BDIn = 1;
        cycle();
        idle();
        chk("wrap_epc", EPCout, 32'hFFFF_FFFC);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] pick [4];
            pick = '{5'd12, 5'd13, 5'd14, 5'($urandom)};
            reset     = ($urandom_range(0, 49) == 0);
            WE        = ($urandom_range(0, 3) == 0);
            A2        = pick[$urandom_range(0, 3)];
            DIn       = $urandom;
            EXLClr    = ($urandom_range(0, 5) == 0);
            ExcCodeIn = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
            HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            BDIn      = 1'($urandom);
            VPC       = $urandom;
            A1        = pick[$urandom_range(0, 3)];
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
